// File: rtl/l2_line_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_line_reader_pkg
// Purpose  : Shared L2 line/word types, geometry and access-size codes.
// Revision : 1.0
// ============================================================================
package l2_line_reader_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int BITS_PER_WORD  = 64;
    localparam int BYTES_PER_WORD = BITS_PER_WORD / 8;
    localparam int BYTE_BITS      = $clog2(BYTES_PER_WORD);
    localparam int WORD_BITS      = $clog2(WORDS_PER_LINE);

    typedef logic [BITS_PER_WORD-1:0]  word_t;
    typedef word_t [WORDS_PER_LINE-1:0] line_t;
    typedef logic [WORD_BITS-1:0]      word_offset_t;
    typedef logic [BYTE_BITS-1:0]      byte_offset_t;
    typedef logic [1:0]                hsize_t;
    typedef logic [WORDS_PER_LINE-1:0] word_mask_t;

    localparam hsize_t BYTE     = 2'd0;
    localparam hsize_t HALFWORD = 2'd1;
    localparam hsize_t WORD_32  = 2'd2;
    localparam hsize_t WORD_64  = 2'd3;

    // Field width in bytes, saturated at the word width so WORD_32 is the
    // full word on 32-bit configurations.
    function automatic int size_bytes(input hsize_t hsize);
        int n;
        n = 1 << hsize;
        return (n > BYTES_PER_WORD) ? BYTES_PER_WORD : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/l2_line_reader_word_extract.sv
`default_nettype none
// ============================================================================
// Module   : l2_word_extract
// Purpose  : Combinational sub-word field extraction with endian/size lanes.
// Revision : 1.0
// ============================================================================
module l2_word_extract
    import l2_line_reader_pkg::*;
#(
    parameter bit ZERO_FILL = 1'b1
) (
    input  word_t        i_word,
    input  byte_offset_t i_b_off,
    input  hsize_t       i_hsize,
    output word_t        o_word
);

    int                        w_width;
    int                        w_lane;
    logic [BYTES_PER_WORD-1:0] w_byte_en;

    always_comb begin
        w_width   = size_bytes(i_hsize);
        w_byte_en = '0;
        if (w_width == BYTES_PER_WORD) begin
            w_lane = 0;
        end else begin
`ifdef BIG_ENDIAN
            w_lane = BYTES_PER_WORD - w_width - int'(i_b_off);
`else
            w_lane = int'(i_b_off);
`endif
        end
        // Misaligned fields simply clip at the word edge; result stays X-free.
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            w_byte_en[i] = (i >= w_lane) && (i < w_lane + w_width);
        end
    end

    for (genvar g = 0; g < BYTES_PER_WORD; g++) begin : g_byte
        assign o_word[g*8 +: 8] = (w_byte_en[g] || !ZERO_FILL) ? i_word[g*8 +: 8] : 8'h00;
    end

endmodule
`default_nettype wire

// File: rtl/l2_line_reader.sv
`default_nettype none
// ============================================================================
// Module   : l2_line_reader
// Purpose  : Serialises masked sub-word reads of a buffered L2 line as beats.
// Revision : 1.0
// ============================================================================
module l2_line_reader
    import l2_line_reader_pkg::*;
#(
    parameter bit ZERO_FILL = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  line_t        line_in,
    input  word_mask_t   word_mask_in,
    input  hsize_t       hsize_in,
    input  byte_offset_t b_off_in,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output word_t        word_out,
    output word_offset_t w_off_out,
    output logic         last_out
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t       r_state;
    line_t        r_line;
    word_mask_t   r_mask;
    hsize_t       r_hsize;
    byte_offset_t r_b_off;

    word_offset_t w_low_idx;
    logic         w_one_hot;
    logic         w_beat_done;
    logic         w_accept;

    always_comb begin
        w_low_idx = '0;
        for (int i = WORDS_PER_LINE - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_idx = word_offset_t'(i);
            end
        end
    end

    assign w_one_hot   = (r_mask != '0) && ((r_mask & (r_mask - word_mask_t'(1))) == '0);
    assign rsp_valid   = (r_state == S_SEND);
    assign last_out    = w_one_hot;
    assign w_off_out   = w_low_idx;
    // Accepting during the final beat lets the next burst start with no bubble.
    assign req_ready   = (r_state == S_IDLE) || (rsp_valid && rsp_ready && w_one_hot);
    assign w_beat_done = rsp_valid && rsp_ready;
    assign w_accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_line  <= '0;
            r_mask  <= '0;
            r_hsize <= '0;
            r_b_off <= '0;
        end else begin
            if (w_beat_done) begin
                r_mask <= r_mask & ~(word_mask_t'(1) << w_low_idx);
                if (w_one_hot) begin
                    r_state <= S_IDLE;
                end
            end
            // A zero-mask request is swallowed without leaving IDLE.
            if (w_accept && (word_mask_in != '0)) begin
                r_state <= S_SEND;
                r_line  <= line_in;
                r_mask  <= word_mask_in;
                r_hsize <= hsize_in;
                r_b_off <= b_off_in;
            end
        end
    end

    l2_word_extract #(
        .ZERO_FILL (ZERO_FILL)
    ) u_extract (
        .i_word  (r_line[w_low_idx]),
        .i_b_off (r_b_off),
        .i_hsize (r_hsize),
        .o_word  (word_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_l2_line_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_line_reader
// Purpose  : Directed self-checking bench for l2_line_reader.
// Revision : 1.0
// ============================================================================
module tb_l2_line_reader;
    import l2_line_reader_pkg::*;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    line_t        line_in;
    word_mask_t   word_mask_in;
    hsize_t       hsize_in;
    byte_offset_t b_off_in;
    logic         rsp_valid;
    logic         rsp_ready;
    word_t        word_out;
    word_offset_t w_off_out;
    logic         last_out;

    int n_checks = 0;
    int n_errors = 0;

    l2_line_reader #(
        .ZERO_FILL (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .line_in      (line_in),
        .word_mask_in (word_mask_in),
        .hsize_in     (hsize_in),
        .b_off_in     (b_off_in),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .word_out     (word_out),
        .w_off_out    (w_off_out),
        .last_out     (last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [1:0] off, input word_t w, input logic lst);
        check({tag, ".valid"}, 64'(rsp_valid), 64'd1);
        check({tag, ".w_off"}, 64'(w_off_out), 64'(off));
        check({tag, ".word"},  word_out,       w);
        check({tag, ".last"},  64'(last_out),  64'(lst));
    endtask

    task automatic drive_req(input line_t l, input word_mask_t m, input hsize_t h, input byte_offset_t b);
        req_valid    = 1'b1;
        line_in      = l;
        word_mask_in = m;
        hsize_in     = h;
        b_off_in     = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t la;
        line_t lb;

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        line_in = '0; word_mask_in = '0; hsize_in = BYTE; b_off_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst.req_ready", 64'(req_ready), 64'd1);
        check("rst.word_out",  word_out,       64'd0);
        check("rst.w_off",     64'(w_off_out), 64'd0);
        check("rst.last",      64'(last_out),  64'd0);

        // Full-word burst, mask 1011; b_off must be ignored for full size
        la[0] = 64'h0000_0000_0000_0A0A; la[1] = 64'h1111_2222_3333_4444;
        la[2] = 64'hDEAD_DEAD_DEAD_DEAD; la[3] = 64'hCAFE_F00D_1234_5678;
        @(posedge clk); #1 drive_req(la, 4'b1011, WORD_64, 3'd3);
        @(negedge clk); check("t1.req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); check_beat("t1.b0", 2'd0, la[0], 1'b0); check("t1.rr0", 64'(req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk); check_beat("t1.b1", 2'd1, la[1], 1'b0); check("t1.rr1", 64'(req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk); check_beat("t1.b3", 2'd3, la[3], 1'b1); check("t1.rr3", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk); check("t1.done", 64'(rsp_valid), 64'd0);

        // Byte read at offset 5
        la = '0; la[0] = 64'h8877_6655_4433_2211;
        @(posedge clk); #1 drive_req(la, 4'b0001, BYTE, 3'd5);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); check_beat("t2.b0", 2'd0, 64'h0000_6600_0000_0000, 1'b1);
        @(posedge clk);
        @(negedge clk); check("t2.done", 64'(rsp_valid), 64'd0);

        // Halfword read held under backpressure for 3 cycles
        la = '0; la[2] = 64'hFEDC_BA98_7654_3210;
        @(posedge clk); #1 drive_req(la, 4'b0100, HALFWORD, 3'd2); rsp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_beat("t3.hold", 2'd2, 64'h0000_0000_7654_0000, 1'b1);
            check("t3.hold_rr", 64'(req_ready), 64'd0);
            @(posedge clk);
        end
        #1 rsp_ready = 1'b1;
        @(negedge clk); check_beat("t3.take", 2'd2, 64'h0000_0000_7654_0000, 1'b1);
        check("t3.take_rr", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk); check("t3.done", 64'(rsp_valid), 64'd0);

        // Chaining: second request accepted on the last beat of the first
        la[0] = 64'h0101_0101_0101_0101; la[1] = 64'h0202_0202_0202_0202;
        la[2] = '0; la[3] = '0;
        lb = '0; lb[3] = 64'h1122_3344_5566_7788;
        @(posedge clk); #1 drive_req(la, 4'b0011, WORD_64, 3'd0);
        @(posedge clk); #1 drive_req(lb, 4'b1000, WORD_32, 3'd4);
        @(negedge clk); check_beat("t4.a0", 2'd0, la[0], 1'b0); check("t4.a0_rr", 64'(req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk); check_beat("t4.a1", 2'd1, la[1], 1'b1); check("t4.a1_rr", 64'(req_ready), 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); check_beat("t4.b3", 2'd3, 64'h1122_3344_0000_0000, 1'b1);
        @(posedge clk);
        @(negedge clk); check("t4.done", 64'(rsp_valid), 64'd0);

        // Zero mask is consumed silently; following request served normally
        la = '0; la[1] = 64'h0123_4567_89AB_CDEF;
        @(posedge clk); #1 drive_req(la, 4'b0000, WORD_64, 3'd0);
        @(negedge clk); check("t5.rr", 64'(req_ready), 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); check("t5.no_valid", 64'(rsp_valid), 64'd0); check("t5.rr_after", 64'(req_ready), 64'd1);
        @(posedge clk); #1 drive_req(la, 4'b0010, BYTE, 3'd0);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); check_beat("t5.b1", 2'd1, 64'h0000_0000_0000_00EF, 1'b1);
        @(posedge clk);

        // Asynchronous reset on the 2nd beat of a 3-beat burst
        la[0] = 64'hAAAA_0000_0000_0001; la[1] = 64'hAAAA_0000_0000_0002;
        la[2] = 64'hAAAA_0000_0000_0003; la[3] = '0;
        @(posedge clk); #1 drive_req(la, 4'b0111, WORD_64, 3'd0);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); check_beat("t6.b0", 2'd0, la[0], 1'b0);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("t6.async_valid", 64'(rsp_valid), 64'd0);
        check("t6.async_rr",    64'(req_ready), 64'd1);
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("t6.post_valid", 64'(rsp_valid), 64'd0);
            check("t6.post_rr",    64'(req_ready), 64'd1);
            check("t6.post_last",  64'(last_out),  64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/l2_line_reader.md
# l2_line_reader

Serialises sub-word reads out of a buffered L2 cache line. It accepts one line plus a per-word select mask and access size. It then emits one aligned, masked word per selected word offset, lowest offset first, over a valid/ready handshake. It sits between the L2 data array read port and the response/forward path. It is the read-side counterpart of the sub-word line writer.

## Interface
Parameters:
- ZERO_FILL, default 1: 1 = bytes outside the accessed field are driven 0 in word_out; 0 = full stored word is driven.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- line_in  in  line_t  line to read
- word_mask_in  in  word_mask_t (`WORDS_PER_LINE`)  bit i = emit word i
- hsize_in  in  hsize_t  access size: `BYTE`, `HALFWORD`, `WORD_32`, or full word
- b_off_in  in  byte_offset_t  byte offset within each word; same for all beats
- rsp_valid  out  1  beat present
- rsp_ready  in  1  beat consumed when rsp_valid && rsp_ready
- word_out  out  word_t  extracted word
- w_off_out  out  word_offset_t  word index of current beat
- last_out  out  1  current beat is the final selected word

## Operation
- State machine has two states: IDLE and SEND.
  - IDLE: req_ready=1, rsp_valid=0.
  - SEND: rsp_valid=1.
- In SEND, the block holds line_r, mask_r, hsize_r and b_off_r.
- Request acceptance:
  - Accept with nonzero mask: capture all inputs and go to SEND.
  - Accept with zero mask: the request is consumed, no beat is produced, and the block stays in IDLE.
- Current beat: w_off_out = index of the lowest set bit of mask_r. last_out=1 iff mask_r has exactly one set bit.
- Beat consumed:
  - Clear that bit in mask_r.
  - If last_out, return to IDLE. If req_valid is also high in that cycle, accept the new request (see the next rule).
- Chaining: req_ready = IDLE || (SEND && rsp_ready && last_out). This allows back-to-back bursts with no bubble.
- Extraction, little-endian:
  - Field byte lane = b_off_r.
  - Field width is 8, 16, 32 or 64 for `BYTE`, `HALFWORD`, `WORD_32` and full word.
  - word_out keeps the field at its natural lane.
  - When ZERO_FILL=1, all other bits are 0.
- Extraction, `BIG_ENDIAN` defined:
  - Field byte lane = `BYTES_PER_WORD` − width_bytes − b_off_r.
  - When `BYTE_BITS`==2, `WORD_32` is the full word.
- Full-word size ignores b_off_r.
- Misaligned (b_off + width > word) is illegal. Output for that case is unspecified but must be X-free.
- word_out, w_off_out and last_out must be stable while rsp_valid && !rsp_ready.

## Timing
- Reset values: state=IDLE, mask_r=0, all registers 0. Outputs: rsp_valid=0, req_ready=1, word_out=0, w_off_out=0, last_out=0.
- Latency: request accepted at edge N gives rsp_valid=1 after edge N, i.e. first beat visible in cycle N+1.
- Throughput: one beat per cycle with rsp_ready held high. A k-bit mask occupies k cycles.
- Outputs are driven from registered state plus combinational extraction. There is no combinational path from req_* to rsp_*.
- Reset asserted mid-burst: the remaining beats are dropped and the block is in IDLE immediately (asynchronous).
- Backpressure: with rsp_ready low, state is frozen indefinitely.

## Structure
- Shared types/constants in the existing spandex package headers: line_t, word_t, word_offset_t, byte_offset_t, hsize_t, word_mask_t, `WORDS_PER_LINE`, `BITS_PER_WORD`, `BYTES_PER_WORD`, `BYTE_BITS`, and the size codes.
- Add no new package types. The FSM state enum is local to the module.
- One natural sub-module: l2_word_extract, combinational (word_t, byte_offset_t, hsize_t → word_t). It holds the endian/size lane logic and can be reused by other read paths.
- Lowest-set-bit priority encoder and one-hot count stay inline.

## Test plan
All scenarios use `WORDS_PER_LINE`=4, 64-bit words, little-endian, ZERO_FILL=1.
- Full-word burst: mask=4'b1011, hsize=full, line words = {W3,W2,W1,W0}, rsp_ready=1 → beats (0,W0,last=0), (1,W1,0), (3,W3,1) in consecutive cycles; req_ready low for 2 cycles, then high.
- Byte read: word0=64'h8877_6655_4433_2211, mask=4'b0001, hsize=`BYTE`, b_off=5 → word_out=64'h0000_6600_0000_0000, last=1.
- Halfword read with backpressure: mask=4'b0100, b_off=2, rsp_ready low for 3 cycles → outputs held stable for 4 cycles; beat consumed on the 4th cycle.
- Chaining: second request valid during the last beat of the first → accepted in the same cycle; its first beat appears the next cycle with no bubble.
- Zero mask: req_valid with mask=0 → req_ready stays 1, rsp_valid never asserts, next request is served normally.
- Reset: assert rst asynchronously on the 2nd beat of a 3-beat burst → rsp_valid falls without waiting for clk; after release, req_ready=1 and no stale beat appears.
